// File: rtl/count_monitor.sv
// Watches a free-running 4-bit down counter, locks after LOCK_CNT clean steps,
// and keeps saturating wrap/error statistics while locked.
module count_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       counter,
  input  logic             clr,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky
);

  localparam int unsigned      RUN_W    = 4;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       prev_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0]       expect_c;
  logic             good_c;
  logic             wrap_evt;
  logic             err_evt;

  // Step classification and next-state / event decode.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    wrap_evt = 1'b0;
    err_evt  = 1'b0;
    expect_c = prev_q - 4'd1;
    good_c   = (counter == expect_c);

    case (state_q)
      IDLE: begin
        state_d = ACQ;
        run_d   = '0;
      end
      ACQ: begin
        if (good_c) begin
          if (run_q == RUN_LAST) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (good_c) begin
          wrap_evt = (prev_q == 4'd0);
        end else begin
          state_d = ACQ;
          run_d   = '0;
          err_evt = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // State, sample history and registered outputs; clr only touches statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= counter;
      run_q      <= run_d;
      locked     <= (state_d == LOCKED);
      wrap_pulse <= wrap_evt;
      if (clr) begin
        wrap_count <= '0;
        err_count  <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (wrap_evt && (wrap_count != CNT_MAX)) wrap_count <= wrap_count + CNT_W'(1);
        if (err_evt && (err_count != CNT_MAX))   err_count  <= err_count + CNT_W'(1);
        if (err_evt)                              err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: two instances (CNT_W=8 and CNT_W=2) fed identical
// stimulus and compared every cycle against a streak-based behavioural model.
module tb_count_monitor;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] counter = 4'd0;

  logic       a_locked, a_wp, a_sticky;
  logic [7:0] a_wc, a_ec;
  logic       b_locked, b_wp, b_sticky;
  logic [1:0] b_wc, b_ec;

  always #5 clk = ~clk;

  count_monitor #(.LOCK_CNT(LOCK), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .counter(counter), .clr(clr),
    .locked(a_locked), .wrap_pulse(a_wp), .wrap_count(a_wc),
    .err_count(a_ec), .err_sticky(a_sticky)
  );

  count_monitor #(.LOCK_CNT(LOCK), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .counter(counter), .clr(clr),
    .locked(b_locked), .wrap_pulse(b_wp), .wrap_count(b_wc),
    .err_count(b_ec), .err_sticky(b_sticky)
  );

  // Behavioural model: lock means "at least LOCK good steps since the last break".
  bit m_valid  = 0;
  int m_prev   = 0;
  int m_streak = 0;
  bit m_locked = 0;
  bit m_wp     = 0;
  bit m_sticky = 0;
  int m_wc_a = 0, m_ec_a = 0, m_wc_b = 0, m_ec_b = 0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_update(input bit r, input bit c, input int v);
    bit was_locked, good, wrap_ev, err_ev;
    if (r) begin
      m_valid = 0; m_prev = 0; m_streak = 0; m_locked = 0; m_wp = 0;
      m_sticky = 0; m_wc_a = 0; m_ec_a = 0; m_wc_b = 0; m_ec_b = 0;
      return;
    end
    wrap_ev = 0;
    err_ev  = 0;
    if (!m_valid) begin
      m_valid  = 1;
      m_streak = 0;
    end else begin
      was_locked = (m_streak >= LOCK);
      good       = (v == ((m_prev + 15) % 16));
      if (good) begin
        if (was_locked && m_prev == 0) wrap_ev = 1;
        if (m_streak < LOCK) m_streak++;
      end else begin
        if (was_locked) err_ev = 1;
        m_streak = 0;
      end
    end
    m_prev   = v;
    m_locked = (m_streak >= LOCK);
    m_wp     = wrap_ev;
    if (c) begin
      m_wc_a = 0; m_ec_a = 0; m_wc_b = 0; m_ec_b = 0; m_sticky = 0;
    end else begin
      if (wrap_ev) begin m_wc_a = sat_inc(m_wc_a, 255); m_wc_b = sat_inc(m_wc_b, 3); end
      if (err_ev)  begin m_ec_a = sat_inc(m_ec_a, 255); m_ec_b = sat_inc(m_ec_b, 3); end
      if (err_ev)  m_sticky = 1;
    end
  endtask

  // Drive one edge, advance the model, and return at the following falling edge.
  task automatic drive(input bit r, input bit c, input int v);
    rst = r;
    clr = c;
    counter = 4'(v);
    @(posedge clk);
    model_update(r, c, v);
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic feed(input int v);
    drive(0, 0, v);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_locked", int'(a_locked), int'(m_locked));
      check("a_wrap_pulse", int'(a_wp), int'(m_wp));
      check("a_wrap_count", int'(a_wc), m_wc_a);
      check("a_err_count", int'(a_ec), m_ec_a);
      check("a_err_sticky", int'(a_sticky), int'(m_sticky));
      check("b_locked", int'(b_locked), int'(m_locked));
      check("b_wrap_pulse", int'(b_wp), int'(m_wp));
      check("b_wrap_count", int'(b_wc), m_wc_b);
      check("b_err_count", int'(b_ec), m_ec_b);
      check("b_err_sticky", int'(b_sticky), int'(m_sticky));
    end
  end

  initial begin
    int v;
    int r;
    @(negedge clk);
    // Reset for three edges, then a clean run locks on the fifth edge.
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    check("lit_reset_locked", int'(a_locked), 0);
    check("lit_reset_wc", int'(a_wc), 0);
    feed(15); feed(14); feed(13); feed(12);
    check("lit_locked_after_4", int'(a_locked), 0);
    feed(11);
    check("lit_locked_after_5", int'(a_locked), 1);
    check("lit_counts_after_lock", int'(a_wc) + int'(a_ec), 0);

    // Wrap while locked.
    for (int k = 10; k >= 0; k--) feed(k);
    feed(15);
    check("lit_wrap_pulse", int'(a_wp), 1);
    check("lit_wrap_count1", int'(a_wc), 1);
    feed(14);
    check("lit_wrap_pulse_low", int'(a_wp), 0);

    // Skip 9 -> 7 drops lock and records an error; four good steps relock.
    for (int k = 13; k >= 9; k--) feed(k);
    feed(7);
    check("lit_skip_unlock", int'(a_locked), 0);
    check("lit_skip_err", int'(a_ec), 1);
    check("lit_skip_sticky", int'(a_sticky), 1);
    feed(6); feed(5); feed(4);
    check("lit_relock_not_yet", int'(a_locked), 0);
    feed(3);
    check("lit_relock", int'(a_locked), 1);

    // Held value: only the first hold counts; a wrap during ACQ is ignored.
    feed(2); feed(2);
    check("lit_hold_err1", int'(a_ec), 2);
    feed(2);
    check("lit_hold_err2", int'(a_ec), 2);
    check("lit_hold_unlocked", int'(a_locked), 0);
    feed(1); feed(0); feed(15);
    check("lit_acq_wrap_ignored", int'(a_wc), 1);
    feed(14);
    check("lit_relock2", int'(a_locked), 1);

    // Four more wraps: the 2-bit instance saturates at 3.
    v = 14;
    for (int i = 0; i < 64; i++) begin v = (v + 15) % 16; feed(v); end
    check("lit_wc8_5", int'(a_wc), 5);
    check("lit_wc2_sat", int'(b_wc), 3);

    // clr on the wrap edge: stats cleared, pulse and lock unaffected.
    while (v != 0) begin v = (v + 15) % 16; feed(v); end
    drive(0, 1, 15);
    v = 15;
    check("lit_clr_wp", int'(a_wp), 1);
    check("lit_clr_wc", int'(a_wc), 0);
    check("lit_clr_sticky", int'(a_sticky), 0);
    check("lit_clr_locked", int'(a_locked), 1);

    // Two more wraps, then a one-edge reset and a five-edge relock.
    for (int i = 0; i < 32; i++) begin v = (v + 15) % 16; feed(v); end
    check("lit_wc_two", int'(a_wc), 2);
    drive(1, 1, 3);
    check("lit_rst_locked", int'(a_locked), 0);
    check("lit_rst_wc", int'(a_wc), 0);
    v = 9;
    for (int i = 0; i < 4; i++) begin feed(v); v = (v + 15) % 16; end
    check("lit_rst_relock_pending", int'(a_locked), 0);
    feed(v);
    check("lit_rst_relock", int'(a_locked), 1);

    // Randomized phase: mostly clean steps with glitches, holds, clr and rst.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)      v = int'($urandom_range(0, 15));
      else if (r < 6) v = v;
      else            v = (v + 15) % 16;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, number of consecutive correct decrements needed to declare lock (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, width of wrap_count and err_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port counter  input  4  value from the upstream 4-bit down counter, sampled every clk edge.
REQ-006 SHALL have port clr  input  1  synchronous clear of statistics (wrap_count, err_count, err_sticky).
REQ-007 SHALL have port locked  output  1  high while FSM is in LOCKED.
REQ-008 SHALL have port wrap_pulse  output  1  one-cycle pulse per detected 0->15 wrap while locked.
REQ-009 SHALL have port wrap_count  output  CNT_W  saturating count of wraps detected while locked.
REQ-010 SHALL have port err_count  output  CNT_W  saturating count of sequence errors detected while locked.
REQ-011 SHALL have port err_sticky  output  1  set on any error while locked; held until clr or rst.

Function
REQ-012 SHALL hold internal register prev[3:0] = counter sampled on previous edge; prev updates every edge outside reset.
REQ-013 SHALL define a good step as counter == (prev - 1) mod 16; 0 -> 15 is a good step and a wrap.
REQ-014 SHALL implement FSM states IDLE, ACQ, LOCKED, with IDLE as the reset state.
REQ-015 IDLE: on the next edge SHALL capture prev <= counter, clear run counter, go to ACQ; no step check.
REQ-016 ACQ: good step with run == LOCK_CNT-1 SHALL go to LOCKED and clear run; other good step SHALL increment run.
REQ-017 ACQ: bad step (including held value) SHALL clear run, stay in ACQ; no error counted, no wrap counted.
REQ-018 LOCKED: good step SHALL stay in LOCKED; if also a wrap, wrap_pulse SHALL be 1 the following cycle and wrap_count SHALL increment.
REQ-019 LOCKED: bad step SHALL go to ACQ, clear run, increment err_count, set err_sticky, in the same edge.
REQ-020 locked, wrap_pulse SHALL be registered outputs (1-cycle latency from the sampled edge); wrap_pulse low in all other cycles.
REQ-021 wrap_count and err_count SHALL saturate at 2^CNT_W-1 and never roll over.
REQ-022 clr SHALL zero wrap_count, err_count, err_sticky on the edge it is sampled; clr SHALL win over a simultaneous increment or set (that event is dropped); clr SHALL NOT affect FSM, prev, run, locked, or wrap_pulse.
REQ-023 With LOCK_CNT=4 and a clean decrementing input, locked SHALL rise after the 5th edge following rst deassertion (1 capture + 4 good steps).

Reset
REQ-024 While rst is high at an edge: state=IDLE, prev=0, run=0, locked=0, wrap_pulse=0, wrap_count=0, err_count=0, err_sticky=0.
REQ-025 rst SHALL override clr and all events; reset asserted mid-operation (any state) SHALL take effect on that edge with no partial update.

Verification
REQ-026 rst high 3 cycles, then counter 15,14,13,12,11 on edges 1-5 -> locked=0 after edges 1-4, locked=1 after edge 5; all counts 0.
REQ-027 Locked, counter ... 1,0,15,14 -> wrap_pulse=1 exactly one cycle after the edge sampling 15; wrap_count=1; err_count=0.
REQ-028 Locked, prev=9, counter=7 (skip) -> locked=0 next cycle, err_count=1, err_sticky=1; then 6,5,4,3 -> locked=1 again after 4th good step.
REQ-029 Locked, counter held at 5 for 2 edges -> err_count=1 (only first counted, second in ACQ), locked=0; wrap at 0->15 during ACQ -> wrap_count unchanged.
REQ-030 CNT_W=2, 5 wraps while locked -> wrap_count sticks at 3; clr asserted on the edge of a wrap -> wrap_count=0, err_sticky=0, wrap_pulse still 1, locked unchanged.
REQ-031 Locked with wrap_count=2, rst asserted one edge -> all outputs 0 next cycle, state IDLE; relock takes 5 edges after rst release.
